// File: rtl/serial_pkg.sv
// serial_pkg: constants and state encoding shared by the serial link receiver and transmitter.
package serial_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic [31:0] DEFAULT_DIV = 32'd16;
   localparam logic [31:0] MIN_DIV = 32'd2;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: free-running bit-period counter with clear and half/full-period terminal count.
module bit_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        half,
   input  logic [31:0] div,
   output logic        tc
);
   logic [31:0] cnt;
   assign tc = cnt == (half ? (div >> 1) - 32'd1 : div - 32'd1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= '0;
      else cnt <= clr ? '0 : cnt + 32'd1;
   end
endmodule

// File: rtl/serial_rx.sv
// serial_rx: UART-style frame receiver with a programmable bit period and stop-bit error flag.
module serial_rx #(
   parameter int          DATA_W      = 8,
   parameter logic [31:0] DEFAULT_DIV = 32'd16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       Din,
   input  logic              conf_div,
   input  logic              ctrl_rx_dat,
   input  logic              sin,
   output logic [DATA_W-1:0] Dout,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              busy
);
   import serial_pkg::*;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   state_t            state;
   logic              s1, s, s_prev, tc;
   logic [31:0]       div, div_f;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] sh;
   // counter is held clear in IDLE and restarts on every sample point
   bit_timer u_timer (
      .clk  (clk),
      .reset(reset),
      .clr  (state == IDLE || tc),
      .half (state == START),
      .div  (div_f),
      .tc   (tc)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         {s1, s, s_prev} <= 3'b111;
         div       <= DEFAULT_DIV;
         div_f     <= DEFAULT_DIV;
         idx       <= '0;
         sh        <= '0;
         Dout      <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         s1        <= sin;
         s         <= s1;
         s_prev    <= s;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (conf_div) div <= (Din < MIN_DIV) ? MIN_DIV : Din;
         if (!ctrl_rx_dat) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (s_prev && !s) begin
                  div_f <= div;
                  state <= START;
                  busy  <= 1'b1;
               end
               START: if (tc) begin
                  state <= s ? IDLE : DATA;
                  busy  <= !s;
                  idx   <= '0;
               end
               DATA: if (tc) begin
                  sh[idx] <= s;
                  idx     <= idx + 1'b1;
                  if (idx == IW'(DATA_W - 1)) state <= STOP;
               end
               STOP: if (tc) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (s) begin
                     Dout     <= sh;
                     rx_valid <= 1'b1;
                  end else frame_err <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized frames checked against an event-window model of the receiver.
module tb_serial_rx;
   logic        clk = 0, reset = 0, conf_div = 0, ctrl_rx_dat = 1, sin = 1;
   logic [31:0] Din = 0;
   logic [7:0]  Dout;
   logic        rx_valid, frame_err, busy;
   int          cyc = 0, n_chk = 0, n_fail = 0, div_m = 16, busy_cnt = 0;
   int          last_valid = -1, last_err = -1, last_fall = 0;
   logic [7:0]  dout_m = 0, keep;
   // each window: busy over [e,t), then a valid or error pulse at t
   typedef struct {int e; int t; bit ok; bit err; logic [7:0] d;} win_t;
   win_t wq[$];

   serial_rx #(.DATA_W(8), .DEFAULT_DIV(32'd16)) dut (
      .clk(clk), .reset(reset), .Din(Din), .conf_div(conf_div), .ctrl_rx_dat(ctrl_rx_dat),
      .sin(sin), .Dout(Dout), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bit b, v, f;
      b = 0; v = 0; f = 0;
      if (!reset) dout_m = 0;
      else foreach (wq[i]) begin
         if (cyc >= wq[i].e && cyc < wq[i].t) b = 1;
         if (cyc == wq[i].t && wq[i].ok) begin v = 1; dout_m = wq[i].d; end
         if (cyc == wq[i].t && wq[i].err) f = 1;
      end
      chk("busy", busy, b);
      chk("rx_valid", rx_valid, v);
      chk("frame_err", frame_err, f);
      chk("Dout", Dout, dout_m);
      if (busy) busy_cnt++;
      if (rx_valid) last_valid = cyc;
      if (frame_err) last_err = cyc;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_conf(input int din);
      Din = din; conf_div = 1; tick(1); conf_div = 0;
      div_m = (din < 2) ? 2 : din;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop);
      int c, p, e, t;
      p = div_m; c = cyc; e = c + 3; t = e + (p >> 1) + 9 * p;
      last_fall = c + 1;
      wq.push_back('{e, t, stop, !stop, d});
      sin = 0; tick(p);
      for (int i = 0; i < 8; i++) begin sin = d[i]; tick(p); end
      sin = stop; tick(p); sin = 1;
      while (cyc < t + 2) tick(1);
   endtask

   task automatic glitch();
      int e;
      e = cyc + 3;
      wq.push_back('{e, e + (div_m >> 1), 1'b0, 1'b0, 8'h00});
      busy_cnt = 0;
      sin = 0; tick(1); sin = 1;
      tick((div_m >> 1) + 6);
   endtask

   initial begin
      int c, a, r;
      tick(3); reset = 1; tick(3);
      // nominal frame at 4 clk/bit
      do_conf(4);
      send_frame(8'hA5, 1);
      chk("a5_dout", Dout, 8'hA5);
      chk("a5_latency", last_valid - last_fall, 40);
      // bad stop bit
      send_frame(8'h3C, 0);
      chk("err_dout", Dout, 8'hA5);
      chk("err_latency", last_err - last_fall, 40);
      // one-cycle glitch at 8 clk/bit
      do_conf(8);
      glitch();
      chk("glitch_busy", busy_cnt, 4);
      // divisor reload mid-frame
      fork
         send_frame(8'h5A, 1);
         begin tick(42); do_conf(2); end
      join
      chk("mid_conf_dout", Dout, 8'h5A);
      send_frame(8'h81, 1);
      chk("fast_dout", Dout, 8'h81);
      // Din below minimum, then enable dropped mid-frame
      do_conf(1);
      send_frame(8'h6E, 1);
      chk("min_div_dout", Dout, 8'h6E);
      keep = Dout;
      c = cyc; a = c + 3 + 3 * div_m;
      wq.push_back('{c + 3, a + 1, 1'b0, 1'b0, 8'h00});
      sin = 0; tick(a - c); ctrl_rx_dat = 0;
      tick(3); sin = 1; tick(4); ctrl_rx_dat = 1; tick(4);
      chk("abort_dout", Dout, keep);
      // reset during DATA
      do_conf(6);
      c = cyc; r = c + 18;
      wq.push_back('{c + 3, r, 1'b0, 1'b0, 8'h00});
      sin = 0; tick(r - c); reset = 0; div_m = 16;
      #1;
      chk("rst_dout", Dout, 0);
      chk("rst_busy", busy, 0);
      sin = 1; tick(2); reset = 1; tick(3);
      send_frame(8'hFF, 1);
      chk("post_rst_dout", Dout, 8'hFF);
      chk("post_rst_latency", last_valid - last_fall, 2 + 8 + 9 * 16);
      // randomized traffic
      for (int k = 0; k < 30; k++) begin
         do_conf($urandom_range(0, 12));
         tick($urandom_range(1, 5));
         if ($urandom_range(0, 5) == 0) glitch();
         else send_frame(8'($urandom), $urandom_range(0, 7) != 0);
      end
      tick(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
